// File: rtl/ir_carrier_pkg.sv
// Shared types, frequency table and period/high-time helpers for the IR carrier generator.
package ir_carrier_pkg;

  typedef enum logic [1:0] {
    FREQ_36K  = 2'd0,
    FREQ_37K5 = 2'd1,
    FREQ_40K  = 2'd2,
    FREQ_38K  = 2'd3
  } freq_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  // Carrier frequencies in tenths of a hertz so that 37.5 kHz stays an integer.
  localparam int unsigned FREQ_36K_DHZ  = 32'd360_000;
  localparam int unsigned FREQ_37K5_DHZ = 32'd375_000;
  localparam int unsigned FREQ_40K_DHZ  = 32'd400_000;
  localparam int unsigned FREQ_38K_DHZ  = 32'd380_000;

  function automatic int unsigned freq_dhz_of(input freq_sel_t sel);
    int unsigned f;
    case (sel)
      FREQ_36K:  f = FREQ_36K_DHZ;
      FREQ_37K5: f = FREQ_37K5_DHZ;
      FREQ_40K:  f = FREQ_40K_DHZ;
      default:   f = FREQ_38K_DHZ;
    endcase
    return f;
  endfunction

  function automatic int unsigned period_of(input freq_sel_t sel, input int unsigned clk_in_freq);
    longint unsigned num;
    num = 64'(clk_in_freq) * 64'd10;
    return 32'(num / 64'(freq_dhz_of(sel)));
  endfunction

  function automatic int unsigned high_of(input int unsigned period, input int unsigned duty_pct);
    return 32'((64'(period) * 64'(duty_pct)) / 64'd100);
  endfunction

endpackage

// File: rtl/ir_carrier_period_ctr.sv
// Carrier phase counter: counts 0..P-1 and registers CARRIER_OUT and PERIOD_TICK
// from the next count value so both line up with the count they describe.
module ir_carrier_period_ctr #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_load,
  input  logic             i_run,
  input  logic             i_last,
  input  logic [CNT_W-1:0] i_period_m1,
  input  logic [CNT_W-1:0] i_high,
  output logic             o_carrier,
  output logic             o_tick
);

  logic [CNT_W-1:0] r_cnt;
  logic             r_carrier;
  logic             r_tick;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_active_nxt;

  // r_tick marks cnt == P-1, so it doubles as the period-boundary flag.
  always_comb begin
    w_cnt_nxt    = '0;
    w_active_nxt = 1'b0;
    if (i_load) begin
      w_active_nxt = 1'b1;
    end else if (i_run) begin
      if (r_tick) begin
        w_active_nxt = !i_last;
      end else begin
        w_cnt_nxt    = r_cnt + CNT_W'(1);
        w_active_nxt = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt     <= '0;
      r_carrier <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_nxt;
      r_carrier <= w_active_nxt && (w_cnt_nxt < i_high);
      r_tick    <= w_active_nxt && (w_cnt_nxt == i_period_m1);
    end
  end

  assign o_carrier = r_carrier;
  assign o_tick    = r_tick;

endmodule

// File: rtl/ir_carrier_gen.sv
// IR carrier generator with counted or continuous bursts (IDLE/RUN FSM, period/stop control).
// Define IR_CARRIER_RETUNE_EN to re-sample FREQ_SEL at every period boundary.
module ir_carrier_gen
  import ir_carrier_pkg::*;
#(
  parameter int unsigned CLK_IN_FREQ = 100_000_000,
  parameter int unsigned DUTY_PCT    = 50,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned BURST_W     = 16
) (
  input  logic               CLK,
  input  logic               RESETN,
  input  logic               START,
  input  logic               STOP,
  input  logic [1:0]         FREQ_SEL,
  input  logic [BURST_W-1:0] BURST_LEN,
  output logic               CARRIER_OUT,
  output logic               BUSY,
  output logic               PERIOD_TICK,
  output logic               DONE
);

  localparam logic [CNT_W-1:0] PM1_36K  = CNT_W'(period_of(FREQ_36K, CLK_IN_FREQ) - 32'd1);
  localparam logic [CNT_W-1:0] PM1_37K5 = CNT_W'(period_of(FREQ_37K5, CLK_IN_FREQ) - 32'd1);
  localparam logic [CNT_W-1:0] PM1_40K  = CNT_W'(period_of(FREQ_40K, CLK_IN_FREQ) - 32'd1);
  localparam logic [CNT_W-1:0] PM1_38K  = CNT_W'(period_of(FREQ_38K, CLK_IN_FREQ) - 32'd1);
  localparam logic [CNT_W-1:0] H_36K    = CNT_W'(high_of(period_of(FREQ_36K, CLK_IN_FREQ), DUTY_PCT));
  localparam logic [CNT_W-1:0] H_37K5   = CNT_W'(high_of(period_of(FREQ_37K5, CLK_IN_FREQ), DUTY_PCT));
  localparam logic [CNT_W-1:0] H_40K    = CNT_W'(high_of(period_of(FREQ_40K, CLK_IN_FREQ), DUTY_PCT));
  localparam logic [CNT_W-1:0] H_38K    = CNT_W'(high_of(period_of(FREQ_38K, CLK_IN_FREQ), DUTY_PCT));

  state_t             r_state;
  logic               r_busy;
  logic               r_done;
  logic               r_stop_pend;
  logic [BURST_W-1:0] r_blen;
  logic [BURST_W-1:0] r_pcnt;
  freq_sel_t          r_sel;

  logic               w_load;
  logic               w_run;
  logic               w_tick;
  logic               w_carrier;
  logic               w_burst_end;
  logic               w_last;
  freq_sel_t          w_sel_nxt;
  logic [CNT_W-1:0]   w_pm1;
  logic [CNT_W-1:0]   w_high;

  assign w_load      = (r_state == IDLE) && START;
  assign w_run       = (r_state == RUN);
  assign w_burst_end = (r_blen != '0) && (r_pcnt == (r_blen - BURST_W'(1)));
  // A STOP arriving on the boundary cycle itself still ends the run there.
  assign w_last      = w_run && w_tick && (r_stop_pend || STOP || w_burst_end);

  // Selection that governs the next cycle: fresh on load (and on boundaries when retuning).
  always_comb begin
    w_sel_nxt = r_sel;
    if (w_load) begin
      w_sel_nxt = freq_sel_t'(FREQ_SEL);
    end
`ifdef IR_CARRIER_RETUNE_EN
    else if (w_run && w_tick) begin
      w_sel_nxt = freq_sel_t'(FREQ_SEL);
    end
`endif
  end

  always_comb begin
    w_pm1  = PM1_36K;
    w_high = H_36K;
    case (w_sel_nxt)
      FREQ_36K:  begin w_pm1 = PM1_36K;  w_high = H_36K;  end
      FREQ_37K5: begin w_pm1 = PM1_37K5; w_high = H_37K5; end
      FREQ_40K:  begin w_pm1 = PM1_40K;  w_high = H_40K;  end
      FREQ_38K:  begin w_pm1 = PM1_38K;  w_high = H_38K;  end
      default:   begin w_pm1 = PM1_36K;  w_high = H_36K;  end
    endcase
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_stop_pend <= 1'b0;
      r_blen      <= '0;
      r_pcnt      <= '0;
      r_sel       <= FREQ_36K;
    end else begin
      r_done <= 1'b0;
      r_sel  <= w_sel_nxt;
      case (r_state)
        IDLE: begin
          if (START) begin
            r_state     <= RUN;
            r_busy      <= 1'b1;
            r_blen      <= BURST_LEN;
            r_pcnt      <= '0;
            r_stop_pend <= 1'b0;
          end
        end
        RUN: begin
          if (w_last) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_stop_pend <= 1'b0;
            r_pcnt      <= '0;
          end else begin
            if (STOP) begin
              r_stop_pend <= 1'b1;
            end
            // Saturate so a long continuous run never wraps into a false burst end.
            if (w_tick && (r_pcnt != '1)) begin
              r_pcnt <= r_pcnt + BURST_W'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  ir_carrier_period_ctr #(
    .CNT_W(CNT_W)
  ) u_period_ctr (
    .i_clk       (CLK),
    .i_rst_n     (RESETN),
    .i_load      (w_load),
    .i_run       (w_run),
    .i_last      (w_last),
    .i_period_m1 (w_pm1),
    .i_high      (w_high),
    .o_carrier   (w_carrier),
    .o_tick      (w_tick)
  );

  assign CARRIER_OUT = w_carrier;
  assign PERIOD_TICK = w_tick;
  assign BUSY        = r_busy;
  assign DONE        = r_done;

endmodule

// File: tb/tb_ir_carrier_gen.sv
// Self-checking bench for ir_carrier_gen: time-based reference model plus directed and random runs.
module tb_ir_carrier_gen;

  logic        CLK       = 1'b0;
  logic        RESETN    = 1'b0;
  logic        START     = 1'b0;
  logic        STOP      = 1'b0;
  logic [1:0]  FREQ_SEL  = 2'd0;
  logic [15:0] BURST_LEN = 16'd0;
  logic        CARRIER_OUT, BUSY, PERIOD_TICK, DONE;
  logic        d_start   = 1'b0;
  logic        d_car, d_busy, d_tick, d_done;

  int n_checks = 0;
  int n_errors = 0;
  int n_busy = 0, n_high = 0, n_tick = 0, n_done = 0;
  int nd_busy = 0, nd_high = 0, nd_tick = 0, nd_done = 0;
  logic last_car = 1'b0;
  longint tq[$];
  longint cyc = 0;

  // Reference model state: run start time of the current constant-period segment.
  logic   m_busy = 1'b0;
  logic   m_done = 1'b0;
  logic   m_stop = 1'b0;
  longint m_t0   = 0;
  int     m_base = 0;
  int     m_P    = 1;
  int     m_N    = 0;

  always #5 CLK = ~CLK;

  ir_carrier_gen #(
    .CLK_IN_FREQ(100_000_000), .DUTY_PCT(50), .CNT_W(16), .BURST_W(16)
  ) dut (
    .CLK(CLK), .RESETN(RESETN), .START(START), .STOP(STOP),
    .FREQ_SEL(FREQ_SEL), .BURST_LEN(BURST_LEN),
    .CARRIER_OUT(CARRIER_OUT), .BUSY(BUSY), .PERIOD_TICK(PERIOD_TICK), .DONE(DONE)
  );

  ir_carrier_gen #(
    .CLK_IN_FREQ(100_000_000), .DUTY_PCT(25), .CNT_W(16), .BURST_W(16)
  ) dut_d25 (
    .CLK(CLK), .RESETN(RESETN), .START(d_start), .STOP(1'b0),
    .FREQ_SEL(2'd1), .BURST_LEN(16'd1),
    .CARRIER_OUT(d_car), .BUSY(d_busy), .PERIOD_TICK(d_tick), .DONE(d_done)
  );

  function automatic int per_of(input int sel);
    int p;
    case (sel)
      0:       p = 100_000_000 / 36_000;
      1:       p = 200_000_000 / 75_000;
      2:       p = 100_000_000 / 40_000;
      default: p = 100_000_000 / 38_000;
    endcase
    return p;
  endfunction

  function automatic int hi_of(input int p, input int duty);
    return (p * duty) / 100;
  endfunction

  always @(posedge CLK) cyc <= cyc + 1;

  always @(posedge CLK or negedge RESETN) begin : model
    int   ph;
    int   per;
    logic sp;
    if (!RESETN) begin
      m_busy <= 1'b0;
      m_done <= 1'b0;
      m_stop <= 1'b0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        ph  = int'((cyc - m_t0) % longint'(m_P));
        per = m_base + int'((cyc - m_t0) / longint'(m_P));
        sp  = m_stop || STOP;
        if (ph == m_P - 1) begin
          if (sp || (m_N != 0 && per == m_N - 1)) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
            m_stop <= 1'b0;
          end
`ifdef IR_CARRIER_RETUNE_EN
          else begin
            m_base <= per + 1;
            m_t0   <= cyc + 1;
            m_P    <= per_of(int'(FREQ_SEL));
          end
`endif
        end else begin
          m_stop <= sp;
        end
      end else if (START) begin
        m_busy <= 1'b1;
        m_t0   <= cyc + 1;
        m_base <= 0;
        m_P    <= per_of(int'(FREQ_SEL));
        m_N    <= int'(BURST_LEN);
        m_stop <= 1'b0;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s at t=%0t: got %0d, expected %0d", tag, $time, got, exp);
    end
  endtask

  task automatic step();
    int   ph;
    logic ecar;
    logic etick;
    @(posedge CLK);
    #1;
    ecar  = 1'b0;
    etick = 1'b0;
    if (m_busy) begin
      ph    = int'((cyc - m_t0) % longint'(m_P));
      ecar  = (ph < hi_of(m_P, 50));
      etick = (ph == m_P - 1);
    end
    chk("busy", 32'(BUSY), 32'(m_busy));
    chk("carrier", 32'(CARRIER_OUT), 32'(ecar));
    chk("tick", 32'(PERIOD_TICK), 32'(etick));
    chk("done", 32'(DONE), 32'(m_done));
    if (BUSY === 1'b1) begin
      n_busy++;
      last_car = CARRIER_OUT;
    end
    if (CARRIER_OUT === 1'b1) n_high++;
    if (PERIOD_TICK === 1'b1) begin
      n_tick++;
      tq.push_back(cyc);
    end
    if (DONE === 1'b1) n_done++;
    if (d_busy === 1'b1) nd_busy++;
    if (d_car === 1'b1) nd_high++;
    if (d_tick === 1'b1) nd_tick++;
    if (d_done === 1'b1) nd_done++;
  endtask

  task automatic pulse_start(input int f, input int n, input logic with_stop);
    FREQ_SEL  = 2'(f);
    BURST_LEN = 16'(n);
    START     = 1'b1;
    STOP      = with_stop;
    step();
    START     = 1'b0;
    STOP      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = (DONE === 1'b1);
    for (int i = 0; i < budget && !seen; i++) begin
      step();
      seen = (DONE === 1'b1);
    end
    chk(tag, 32'(seen), 32'd1);
  endtask

  initial begin : main
    int b0, h0, t0, d0, q0;
    int exp_p2;
    bit seen;

    repeat (3) step();
    chk("rst_carrier", 32'(CARRIER_OUT), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    chk("rst_tick", 32'(PERIOD_TICK), 32'd0);
    chk("rst_done", 32'(DONE), 32'd0);
    RESETN = 1'b1;
    repeat (2) step();

    // Burst of three 40 kHz periods.
    b0 = n_busy; h0 = n_high; t0 = n_tick; d0 = n_done; q0 = tq.size();
    pulse_start(2, 3, 1'b0);
    wait_done("burst_done", 8000);
    chk("burst_busy", 32'(n_busy - b0), 32'd7500);
    chk("burst_high", 32'(n_high - h0), 32'd3750);
    chk("burst_ticks", 32'(n_tick - t0), 32'd3);
    chk("burst_dones", 32'(n_done - d0), 32'd1);
    for (int i = q0; i + 1 < tq.size(); i++) chk("burst_gap", 32'(tq[i+1] - tq[i]), 32'd2500);

    // Continuous 36 kHz, STOP at cnt=100 of period 5 (back-to-back with the DONE cycle).
    b0 = n_busy; t0 = n_tick; d0 = n_done;
    pulse_start(0, 0, 1'b0);
    repeat (4 * 2777 + 100) step();
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    wait_done("cont_done", 6000);
    chk("cont_busy", 32'(n_busy - b0), 32'd13885);
    chk("cont_ticks", 32'(n_tick - t0), 32'd5);
    chk("cont_dones", 32'(n_done - d0), 32'd1);
    chk("cont_end_low", 32'(last_car), 32'd0);
    step();

    // START+STOP together in IDLE, then a START while busy: neither changes the 2-period burst.
    b0 = n_busy;
    pulse_start(2, 2, 1'b1);
    repeat (1000) step();
    BURST_LEN = 16'd5;
    START = 1'b1;
    step();
    START = 1'b0;
    wait_done("ign_done", 8000);
    chk("ign_busy", 32'(n_busy - b0), 32'd5000);

    // Back-to-back start in the DONE cycle, 38 kHz single period.
    b0 = n_busy;
    pulse_start(3, 1, 1'b0);
    chk("b2b_busy_now", 32'(BUSY), 32'd1);
    wait_done("b2b_done", 3000);
    chk("b2b_busy", 32'(n_busy - b0), 32'd2631);

    // STOP on the very last cycle of the first period.
    b0 = n_busy;
    pulse_start(2, 0, 1'b0);
    repeat (2499) step();
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    wait_done("edge_stop_done", 5);
    chk("edge_stop_busy", 32'(n_busy - b0), 32'd2500);

    // 25 % duty at 37.5 kHz on the second instance.
    b0 = nd_busy; h0 = nd_high; t0 = nd_tick; d0 = nd_done;
    d_start = 1'b1;
    step();
    d_start = 1'b0;
    seen = (d_done === 1'b1);
    for (int i = 0; i < 3000 && !seen; i++) begin
      step();
      seen = (d_done === 1'b1);
    end
    chk("d25_done", 32'(seen), 32'd1);
    chk("d25_busy", 32'(nd_busy - b0), 32'd2666);
    chk("d25_high", 32'(nd_high - h0), 32'd666);
    chk("d25_ticks", 32'(nd_tick - t0), 32'd1);
    chk("d25_dones", 32'(nd_done - d0), 32'd1);

    // Retune 36k -> 40k mid-period.
`ifdef IR_CARRIER_RETUNE_EN
    exp_p2 = 2500;
`else
    exp_p2 = 2777;
`endif
    b0 = n_busy; q0 = tq.size();
    pulse_start(0, 2, 1'b0);
    repeat (1000) step();
    FREQ_SEL = 2'd2;
    wait_done("retune_done", 7000);
    chk("retune_busy", 32'(n_busy - b0), 32'(2777 + exp_p2));
    chk("retune_ticks", 32'(tq.size() - q0), 32'd2);
    for (int i = q0; i + 1 < tq.size(); i++) chk("retune_gap", 32'(tq[i+1] - tq[i]), 32'(exp_p2));
    step();

    // Reset in the middle of a run.
    d0 = n_done;
    pulse_start(1, 0, 1'b0);
    repeat (500) step();
    RESETN = 1'b0;
    #1;
    chk("rmid_carrier", 32'(CARRIER_OUT), 32'd0);
    chk("rmid_busy", 32'(BUSY), 32'd0);
    chk("rmid_tick", 32'(PERIOD_TICK), 32'd0);
    chk("rmid_done", 32'(DONE), 32'd0);
    repeat (2) step();
    RESETN = 1'b1;
    repeat (20) step();
    chk("rmid_no_done", 32'(n_done - d0), 32'd0);

    // Randomized runs with stray STOP/START/FREQ_SEL activity.
    for (int it = 0; it < 6; it++) begin
      int f, n, stop_at, poke_at;
      bit got;
      f       = int'($urandom_range(0, 3));
      n       = int'($urandom_range(0, 2));
      stop_at = -1;
      if (n == 0 || $urandom_range(0, 1) == 1) stop_at = int'($urandom_range(1, 5600));
      poke_at = int'($urandom_range(1, 4000));
      pulse_start(f, n, 1'b0);
      got = 1'b0;
      for (int c = 1; c < 9000 && !got; c++) begin
        STOP  = (c == stop_at);
        START = (c == poke_at);
        if (c == poke_at) begin
          BURST_LEN = 16'($urandom);
          FREQ_SEL  = 2'($urandom_range(0, 3));
        end
        step();
        got = (DONE === 1'b1);
      end
      START = 1'b0;
      STOP  = 1'b0;
      chk("rnd_done", 32'(got), 32'd1);
      STOP = 1'b1;
      step();
      STOP = 1'b0;
      step();
      chk("rnd_idle_stop", 32'(BUSY), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
